// File: rtl/mem_store_checker.sv
// Checker for the CPU data-memory write port. It compares observed stores with a table of
// expected stores, either in program order or in any order, and reports pass, fail or timeout.
module mem_store_checker #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned TOW   = 16,
  localparam int unsigned IW   = $clog2(DEPTH),
  localparam int unsigned CW   = IW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cfg_we,
  input  logic [IW-1:0] i_cfg_idx,
  input  logic [AW-1:0] i_cfg_addr,
  input  logic [DW-1:0] i_cfg_data,
  input  logic [DW-1:0] i_cfg_mask,
  input  logic [CW-1:0] i_num_exp,
  input  logic          i_any_order,
  input  logic [AW-1:0] i_ign_base,
  input  logic [AW-1:0] i_ign_len,
  input  logic          i_start,
  input  logic          i_clear,
  input  logic          i_memwrite,
  input  logic [AW-1:0] i_dataadr,
  input  logic [DW-1:0] i_writedata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [1:0]    o_err_code,
  output logic [AW-1:0] o_err_addr,
  output logic [DW-1:0] o_err_data,
  output logic [CW-1:0] o_match_cnt
);

  typedef enum logic [2:0] {StIdle, StArmed, StPass, StFail, StTout} state_e;

  state_e r_state, w_state_d;

  logic [AW-1:0]    r_tab_addr [DEPTH];
  logic [DW-1:0]    r_tab_data [DEPTH];
  logic [DW-1:0]    r_tab_mask [DEPTH];

  logic [CW-1:0]    r_num_exp;
  logic             r_any_order;
  logic [AW-1:0]    r_ign_base, r_ign_len;
  logic [DEPTH-1:0] r_hit, w_hit_d;
  logic [TOW-1:0]   r_cyc, w_cyc_d;
  logic [CW-1:0]    r_match_cnt, w_match_cnt_d;
  logic [1:0]       r_err_code, w_err_code_d;
  logic [AW-1:0]    r_err_addr, w_err_addr_d;
  logic [DW-1:0]    r_err_data, w_err_data_d;
  logic             r_busy, r_done, r_pass;
  logic             w_busy_d, w_done_d, w_pass_d;

  logic             w_num_ok, w_arm;
  logic [AW:0]      w_adr_x, w_win_lo, w_win_hi;
  logic             w_in_win, w_store;
  logic [IW-1:0]    w_ord_idx;
  logic             w_ord_aeq, w_ord_full;
  logic [DEPTH-1:0] w_any_aeq, w_any_full;
  logic [IW-1:0]    w_any_sel;
  logic             w_match, w_fail, w_last, w_tout;
  logic [1:0]       w_fail_code;
  logic [CW-1:0]    w_cnt_inc;

  assign w_num_ok = (i_num_exp != '0) && (i_num_exp <= CW'(DEPTH));
  assign w_arm    = (r_state == StIdle) && i_start && w_num_ok;

  // Window bounds are compared one bit wider so base+len never wraps.
  assign w_adr_x  = {1'b0, i_dataadr};
  assign w_win_lo = {1'b0, r_ign_base};
  assign w_win_hi = {1'b0, r_ign_base} + {1'b0, r_ign_len};
  assign w_in_win = (r_ign_len != '0) && (w_adr_x >= w_win_lo) && (w_adr_x < w_win_hi);
  assign w_store  = (r_state == StArmed) && i_memwrite && !w_in_win;

  assign w_ord_idx  = r_match_cnt[IW-1:0];
  assign w_ord_aeq  = (r_tab_addr[w_ord_idx] == i_dataadr);
  assign w_ord_full = w_ord_aeq &&
                      (((i_writedata ^ r_tab_data[w_ord_idx]) & r_tab_mask[w_ord_idx]) == '0);

  always_comb begin
    w_any_aeq  = '0;
    w_any_full = '0;
    w_any_sel  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_num_exp) && !r_hit[i] && (r_tab_addr[i] == i_dataadr)) begin
        w_any_aeq[i]  = 1'b1;
        w_any_full[i] = (((i_writedata ^ r_tab_data[i]) & r_tab_mask[i]) == '0);
      end
    end
    // Descending scan leaves the lowest matching index selected.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_any_full[i]) begin
        w_any_sel = IW'(i);
      end
    end
  end

  assign w_match     = w_store && (r_any_order ? (|w_any_full) : w_ord_full);
  assign w_fail      = w_store && !w_match;
  assign w_fail_code = (r_any_order ? (|w_any_aeq) : w_ord_aeq) ? 2'd2 : 2'd1;
  assign w_cnt_inc   = r_match_cnt + 1'b1;
  assign w_last      = (w_cnt_inc == r_num_exp);
  assign w_tout      = (r_cyc == '1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_arm) w_state_d = StArmed;
      end
      StArmed: begin
        if (i_clear) begin
          w_state_d = StIdle;
        end else if (w_fail) begin
          w_state_d = StFail;
        end else if (w_match && w_last) begin
          w_state_d = StPass;
        end else if (!w_match && w_tout) begin
          w_state_d = StTout;
        end
      end
      StPass, StFail, StTout: begin
        if (i_clear) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic, evaluated on the next state so the status flags come out of flops
  always_comb begin
    w_busy_d = (w_state_d == StArmed);
    w_pass_d = (w_state_d == StPass);
    w_done_d = (w_state_d == StPass) || (w_state_d == StFail) || (w_state_d == StTout);
  end

  always_comb begin
    w_match_cnt_d = r_match_cnt;
    w_hit_d       = r_hit;
    w_cyc_d       = r_cyc;
    w_err_code_d  = r_err_code;
    w_err_addr_d  = r_err_addr;
    w_err_data_d  = r_err_data;
    if ((r_state != StIdle) && i_clear) begin
      w_match_cnt_d = '0;
      w_hit_d       = '0;
      w_cyc_d       = '0;
      w_err_code_d  = '0;
      w_err_addr_d  = '0;
      w_err_data_d  = '0;
    end else if (w_arm) begin
      w_match_cnt_d = '0;
      w_hit_d       = '0;
      w_cyc_d       = '0;
      w_err_code_d  = '0;
      w_err_addr_d  = '0;
      w_err_data_d  = '0;
    end else if (r_state == StArmed) begin
      w_cyc_d = r_cyc + 1'b1;
      if (w_fail) begin
        w_err_code_d = w_fail_code;
        w_err_addr_d = i_dataadr;
        w_err_data_d = i_writedata;
      end else if (w_match) begin
        w_match_cnt_d = w_cnt_inc;
        if (r_any_order) w_hit_d[w_any_sel] = 1'b1;
      end else if (w_tout) begin
        w_err_code_d = 2'd3;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num_exp   <= '0;
      r_any_order <= 1'b0;
      r_ign_base  <= '0;
      r_ign_len   <= '0;
      r_match_cnt <= '0;
      r_hit       <= '0;
      r_cyc       <= '0;
      r_err_code  <= '0;
      r_err_addr  <= '0;
      r_err_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      if (w_arm) begin
        r_num_exp   <= i_num_exp;
        r_any_order <= i_any_order;
        r_ign_base  <= i_ign_base;
        r_ign_len   <= i_ign_len;
      end
      r_match_cnt <= w_match_cnt_d;
      r_hit       <= w_hit_d;
      r_cyc       <= w_cyc_d;
      r_err_code  <= w_err_code_d;
      r_err_addr  <= w_err_addr_d;
      r_err_data  <= w_err_data_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_pass      <= w_pass_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tab_addr[i] <= '0;
        r_tab_data[i] <= '0;
        r_tab_mask[i] <= '0;
      end
    end else if ((r_state == StIdle) && i_cfg_we) begin
      r_tab_addr[i_cfg_idx] <= i_cfg_addr;
      r_tab_data[i_cfg_idx] <= i_cfg_data;
      r_tab_mask[i_cfg_idx] <= i_cfg_mask;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_code  = r_err_code;
  assign o_err_addr  = r_err_addr;
  assign o_err_data  = r_err_data;
  assign o_match_cnt = r_match_cnt;

endmodule
